// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Serial transmit stage driven by a debounced send button. A rising edge
// on send while idle launches one LSB-first asynchronous frame carrying din:
// start bit, 8 data bits, optional even parity bit, stop bit. Every bit is
// held for BAUD_CNT = CLK_FREQ/BAUD clock cycles. tx and busy are registered.
// Build option: define TX_PARITY_EN to insert an even parity bit (8E1);
// leave it undefined for plain 8N1.
module uart_tx_serializer #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 19_200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] din,
  output logic       tx,
  output logic       busy
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD;
  localparam int CNT_W    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic             r_send_d;
  logic             r_tx;
  logic             r_busy;

  logic             w_launch;
  logic             w_baud_tc;

  // send_d resets high, so a button held through reset release is not an edge.
  assign w_launch  = send & ~r_send_d & (r_state == S_IDLE);
  assign w_baud_tc = (r_baud_cnt == CNT_W'(BAUD_CNT - 1));

  assign tx   = r_tx;
  assign busy = r_busy;

  // Frame sequencer: edge detect, bit timing, bit selection and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_send_d   <= 1'b1;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_send_d <= send;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            // din is captured here only; later changes cannot disturb the frame.
            r_shift    <= din;
            r_parity   <= ^din;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_baud_tc) begin
            r_baud_cnt <= '0;
            r_tx       <= r_shift[0];
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_baud_tc) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
`ifdef TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              // Shift right so the next data bit is always at position 1.
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
`ifdef TX_PARITY_EN
        S_PARITY: begin
          if (w_baud_tc) begin
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
            r_state    <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_baud_tc) begin
            // Back in IDLE next cycle, so a fresh edge can launch immediately.
            r_baud_cnt <= '0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_baud_cnt <= '0;
          r_tx       <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at CLK_FREQ=1000, BAUD=100 (10 cycles/bit).
// Outputs are sampled on the falling clock edge; inputs change on the falling edge.
module tb_uart_tx_serializer;

  localparam int BC = 10;
`ifdef TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk;
  logic       reset_n;
  logic       send;
  logic [7:0] din;
  logic       tx;
  logic       busy;

  int checks;
  int failures;

  uart_tx_serializer #(
    .CLK_FREQ(1000),
    .BAUD    (100)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .send   (send),
    .din    (din),
    .tx     (tx),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive a rising edge on send with byte b; returns just after the launch edge.
  task automatic launch(input logic [7:0] b);
    @(negedge clk);
    send = 1'b0;
    din  = b;
    @(negedge clk);
    send = 1'b1;
    @(posedge clk);
  endtask

  // Check one frame sample-by-sample starting at the first negedge after launch.
  // glitch >= 0: toggle send and scramble din mid-frame (must be ignored).
  // chain: prepare an edge so the next frame launches the cycle after busy falls.
  task automatic frame_check(input string name, input logic [7:0] b, input int glitch,
                             input bit chain, input logic [7:0] next_b);
    logic [NB-1:0] exp_bits;
    exp_bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) exp_bits[k+1] = b[k];
`ifdef TX_PARITY_EN
    exp_bits[9]  = ^b;
    exp_bits[10] = 1'b1;
`else
    exp_bits[9]  = 1'b1;
`endif
    for (int j = 0; j < NB*BC; j++) begin
      @(negedge clk);
      check($sformatf("%s_tx_s%0d", name, j), 32'(tx), 32'(exp_bits[j/BC]));
      check($sformatf("%s_busy_s%0d", name, j), 32'(busy), 32'd1);
      if (glitch >= 0 && j == glitch) send = 1'b0;
      if (glitch >= 0 && j == glitch + 2) begin
        send = 1'b1;
        din  = ~b;
      end
      if (chain && j == NB*BC - 2) send = 1'b0;
    end
    @(negedge clk);
    check($sformatf("%s_busy_end", name), 32'(busy), 32'd0);
    check($sformatf("%s_tx_end", name), 32'(tx), 32'd1);
    $display("frame %s byte=%02h checked", name, b);
    if (chain) begin
      din  = next_b;
      send = 1'b1;
      @(posedge clk);
    end
  endtask

  // Watch n cycles; report how many had busy high or tx low.
  task automatic quiet(input string name, input int n);
    int nb;
    int nt;
    nb = 0;
    nt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (!tx) nt++;
    end
    check($sformatf("%s_busy_cycles", name), 32'(nb), 32'd0);
    check($sformatf("%s_tx_low_cycles", name), 32'(nt), 32'd0);
    $display("quiet %s %0d cycles", name, n);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    send     = 1'b1;
    din      = 8'h00;

    // 1: reset values, then release with send held high -> no frame.
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    quiet("rel_send_high", 200);

    // 2: A5 frame -> 0,1,0,1,0,0,1,0,1,1 (parity 0 inserted when enabled).
    launch(8'hA5);
    frame_check("a5", 8'hA5, -1, 1'b0, 8'h00);

    // 3: send held high for a long time -> exactly one frame.
    launch(8'h3C);
    frame_check("hold", 8'h3C, -1, 1'b0, 8'h00);
    quiet("hold_after", 200);

    // 4: edge at sample 40 ignored; din change ignored; back-to-back launch.
    launch(8'h81);
    frame_check("glitch", 8'h81, 40, 1'b1, 8'h5A);
    frame_check("b2b", 8'h5A, -1, 1'b0, 8'h00);

    // 5: async reset during data bit 3 (frame bit 4, samples 40..49).
    launch(8'h00);
    for (int j = 0; j < 45; j++) @(negedge clk);
    check("mid_tx_before", 32'(tx), 32'd0);
    check("mid_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    send    = 1'b0;
    reset_n = 1'b1;
    quiet("after_mid_rst", 200);

`ifdef TX_PARITY_EN
    // 6: 07 has three ones -> parity bit 1, frame 110 cycles.
    launch(8'h07);
    frame_check("par07", 8'h07, -1, 1'b0, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
